mem_rw_arb: RTL
===============

Name: mem_rw_arb

Overview:
- Shares the single read/write port of main memory among NREQ requesters: core, front-panel load/look, and halt/in-wait PC readback.
- Round-robin arbiter with stall-stable grants and optional multi-beat lock.
- Routes the one-cycle-late read data back to the requester that issued the read.
- Sits between the requesters and the main memory; replaces the ad-hoc priority muxing in the top-level sequencer.

Parameters:
NREQ, 3, number of requesters (index 0 = highest initial round-robin priority)
AW, 8, address width
DW, 16, data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_val_i  in  NREQ  per-requester request valid
req_rdy_o  out  NREQ  per-requester accept; high only for the granted requester when m_rdy_i is high
req_wen_i  in  NREQ  per-requester write enable
req_lock_i  in  NREQ  keep the grant after this beat is accepted
req_addr_i  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
req_wdata_i  in  NREQ*DW  packed write data
rsp_val_o  out  NREQ  one-cycle read-data valid pulse to the issuing requester
rsp_rdata_o  out  DW  read data, broadcast to all requesters
grant_o  out  NREQ  one-hot current grant (zero when no request)
m_val_o  out  1  memory request valid
m_wen_o  out  1  memory write enable
m_addr_o  out  AW  memory address
m_wdata_o  out  DW  memory write data
m_rdy_i  in  1  memory accept
m_rdata_i  in  DW  memory read data, valid the cycle after an accepted read

Behaviour:
- Reset values:
  - ptr = 0, state = IDLE, hold_id = 0, rsp_pend = 0.
  - rsp_val_o = 0, all-zero requests give grant_o = 0 and m_val_o = 0.
  - Reset mid-transaction drops any pending response pulse.
- Accept = m_val_o && m_rdy_i. m_* outputs are a combinational mux of the granted requester; m_val_o = |(grant_o & req_val_i).
- State IDLE:
  - grant_o = round-robin pick of req_val_i, searching from ptr upward with wrap-around (NREQ-1 wraps to 0). Combinational, so zero cycles of arbitration latency.
  - On accept with req_lock_i[g] = 1 -> LOCK, hold_id = g.
  - On m_val_o && !m_rdy_i -> HOLD, hold_id = g.
  - On accept without lock: stay in IDLE, ptr = g+1 (mod NREQ).
- State HOLD (stalled request):
  - grant_o fixed to hold_id; a higher-priority arrival must not change m_addr_o, m_wen_o or m_wdata_o.
  - On accept -> IDLE (or LOCK if lock is set), ptr = hold_id+1.
  - If req_val_i[hold_id] drops -> IDLE; this is a protocol violation tolerated without hang.
- State LOCK:
  - grant_o fixed to hold_id even while req_val_i[hold_id] = 0; no other requester is served.
  - Exit to IDLE on the first accept with req_lock_i[hold_id] = 0; ptr = hold_id+1.
  - Exit to IDLE if lock and val are both low for a cycle; ptr unchanged.
- Response path:
  - An accepted read (wen = 0) registers rsp_pend = 1, rsp_id = g.
  - Next cycle: rsp_val_o[rsp_id] = 1 and rsp_rdata_o = m_rdata_i (passthrough).
  - Accepted writes produce no response.
  - Back-to-back reads from different requesters pulse rsp_val_o on consecutive cycles with the correct ids.
  - Throughput: 1 beat per cycle when m_rdy_i is held high.
- Width rules: ptr is $clog2(NREQ) bits with explicit wrap, not power-of-two overflow. Grant is always one-hot or zero (assertion).

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e enum {IDLE, HOLD, LOCK}.
  - MEM_AW = 8, MEM_DW = 16.
  - Requester index constants REQ_CORE = 0, REQ_PANEL = 1, REQ_READBACK = 2.
- Sub-module rr_pick: combinational round-robin one-hot picker (inputs req vector and ptr; output one-hot grant). Instantiated once.

Test Plan:
- Reset, then req_val = 3'b111 with m_rdy_i = 1 held for 6 cycles -> grant sequence 001, 010, 100, 001, 010, 100, one accept per cycle.
- Stall: req 1 reads addr 0x20 with m_rdy_i = 0 for 3 cycles; req 0 raises val in cycle 2 -> grant_o stays 010 and m_addr_o stays 0x20 until m_rdy_i = 1. Req 0 is granted the next cycle.
- Read routing: req 2 reads 0x10 (mem returns 0xBEEF), then req 0 reads 0x11 (0x1234) back-to-back -> rsp_val_o = 100 with 0xBEEF, then 001 with 0x1234, on consecutive cycles.
- Lock: req 1 issues write 0x05 with lock = 1, then read 0x05 with lock = 0, while req 0 requests continuously -> req 0 is not granted between the two beats; the read returns the written data; grant then moves to req 0.
- Write: req 0 writes 0xAAAA to 0x30 -> no rsp_val_o pulse; a subsequent read of 0x30 returns 0xAAAA.
- Async reset asserted one cycle after an accepted read -> rsp_val_o stays 0, state IDLE, ptr = 0; the first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory read/write arbiter.
//   arb_state_e  : arbiter state (IDLE = free round-robin, HOLD = stalled
//                  beat pinned, LOCK = multi-beat ownership)
//   MEM_AW/MEM_DW: default memory address / data widths
//   REQ_*        : requester index assignment (lower index = higher
//                  initial round-robin priority)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } arb_state_e;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;

    localparam int REQ_CORE     = 0;
    localparam int REQ_PANEL    = 1;
    localparam int REQ_READBACK = 2;

endpackage

// File: rtl/mem_rw_arb_rr_pick.sv
// Combinational round-robin one-hot picker.
//   req   : request vector
//   ptr   : index with the highest priority this cycle (must be < NREQ)
//   grant : one-hot of the first set request at or above ptr, wrapping
//           from NREQ-1 back to 0; all-zero when req is zero
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // Walk the requesters in priority order starting at ptr; the
        // modulo is done by explicit subtraction since NREQ need not be
        // a power of two.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (idx == i) && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_rw_arb.sv
// Main-memory port arbiter: shares one read/write memory port among NREQ
// requesters (core, front-panel load/look, halt/in-wait PC readback).
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   req_val/wen/lock_i    : per-requester request valid, write enable, and
//                           "keep the grant after this beat"
//   req_addr_i/wdata_i    : packed per-requester address / write data
//   req_rdy_o             : accept, high for the granted requester when the
//                           memory is ready
//   rsp_val_o/rsp_rdata_o : one-cycle read-data pulse to the issuer, with
//                           the memory read data broadcast to all
//   grant_o               : one-hot current grant (zero when idle)
//   m_*                   : memory request port; read data arrives the
//                           cycle after an accepted read
module mem_rw_arb
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]  req_val_i,
    output logic [NREQ-1:0]  req_rdy_o,
    input  logic [NREQ-1:0]  req_wen_i,
    input  logic [NREQ-1:0]  req_lock_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]  rsp_val_o,
    output logic [DW-1:0]    rsp_rdata_o,
    output logic [NREQ-1:0]  grant_o,
    output logic             m_val_o,
    output logic             m_wen_o,
    output logic [AW-1:0]    m_addr_o,
    output logic [DW-1:0]    m_wdata_o,
    input  logic             m_rdy_i,
    input  logic [DW-1:0]    m_rdata_i
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e     state_reg, state_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [IDW-1:0] hold_id_reg, hold_id_next;
    logic [IDW-1:0] rsp_id_reg;
    logic           rsp_pend_reg;

    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] hold_onehot;
    logic [NREQ-1:0] rsp_onehot;
    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [IDW-1:0]  g_idx;
    logic            lock_g;
    logic            accept;

    // Increment with explicit wrap at NREQ-1.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return '0;
        end
        return idx + IDW'(1);
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req_val_i),
        .ptr   (ptr_reg),
        .grant (rr_grant)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]    = req_addr_i[gi*AW +: AW];
            assign wdata_arr[gi]   = req_wdata_i[gi*DW +: DW];
            assign hold_onehot[gi] = (hold_id_reg == IDW'(gi));
            assign rsp_onehot[gi]  = rsp_pend_reg && (rsp_id_reg == IDW'(gi));
        end
    endgenerate

    // Outside IDLE the grant is pinned so a stalled or locked beat keeps
    // its address/data stable whatever else starts requesting.
    assign grant_o   = (state_reg == IDLE) ? rr_grant : hold_onehot;
    assign m_val_o   = |(grant_o & req_val_i);
    assign req_rdy_o = grant_o & {NREQ{m_rdy_i}};
    assign lock_g    = |(grant_o & req_lock_i);
    assign accept    = m_val_o & m_rdy_i;

    // One-hot mux of the granted requester onto the memory port.
    always_comb begin
        m_wen_o   = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        g_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_o[i]) begin
                m_wen_o   = req_wen_i[i];
                m_addr_o  = addr_arr[i];
                m_wdata_o = wdata_arr[i];
                g_idx     = IDW'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hold_id_next = hold_id_reg;
        case (state_reg)
            IDLE: begin
                if (m_val_o) begin
                    hold_id_next = g_idx;
                    if (!m_rdy_i) begin
                        state_next = HOLD;
                    end else if (lock_g) begin
                        // Pointer advances only when the locked run ends.
                        state_next = LOCK;
                    end else begin
                        ptr_next = next_idx(g_idx);
                    end
                end
            end
            HOLD: begin
                if (!m_val_o) begin
                    // Requester withdrew a stalled beat; release rather
                    // than wait forever.
                    state_next = IDLE;
                end else if (m_rdy_i) begin
                    ptr_next   = next_idx(hold_id_reg);
                    state_next = lock_g ? LOCK : IDLE;
                end
            end
            LOCK: begin
                if (accept && !lock_g) begin
                    state_next = IDLE;
                    ptr_next   = next_idx(hold_id_reg);
                end else if (!m_val_o && !lock_g) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            hold_id_reg  <= '0;
            rsp_pend_reg <= 1'b0;
            rsp_id_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            hold_id_reg  <= hold_id_next;
            rsp_pend_reg <= accept & ~m_wen_o;
            rsp_id_reg   <= g_idx;
        end
    end

    // Read data is not registered here: the memory already returns it one
    // cycle after the accept, aligned with rsp_pend_reg.
    assign rsp_val_o   = rsp_onehot;
    assign rsp_rdata_o = m_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(grant_o));
        end
    end

endmodule
